// File: rtl/sm4_pkg.sv
// -----------------------------------------------------------------------------
// sm4_pkg
// Shared constants and types for the SM4 stream scheduler.
//   SM4_MODE_*  : encodings of the core's i_mode input
//   ST_*        : scheduler FSM state encodings
//   sm4_entry_t : one output FIFO entry (result block tagged with its mode)
//   sm4_mode_of : maps a request's decrypt flag to the core mode encoding
// -----------------------------------------------------------------------------
package sm4_pkg;

    localparam int SM4_BLK_W = 128;

    localparam logic [1:0] SM4_MODE_IDLE = 2'b00;
    localparam logic [1:0] SM4_MODE_ENC  = 2'b01;
    localparam logic [1:0] SM4_MODE_DEC  = 2'b10;

    localparam logic [2:0] ST_NOKEY  = 3'd0;
    localparam logic [2:0] ST_KPULSE = 3'd1;
    localparam logic [2:0] ST_KWAIT  = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    typedef struct packed {
        logic                 dec;
        logic [SM4_BLK_W-1:0] data;
    } sm4_entry_t;

    function automatic logic [1:0] sm4_mode_of(input logic dec);
        return dec ? SM4_MODE_DEC : SM4_MODE_ENC;
    endfunction

endpackage

// File: rtl/sm4_out_fifo.sv
// -----------------------------------------------------------------------------
// sm4_out_fifo
// Synchronous first-word-fall-through FIFO holding core results and their mode.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push       : write request (i_wdata)
//   i_pop        : read request; the head is always visible on o_rdata
//   o_empty      : no entries stored
//   o_count      : current occupancy
//   o_drop       : a push was refused because the FIFO was full
// -----------------------------------------------------------------------------
module sm4_out_fifo
    import sm4_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  sm4_entry_t       i_wdata,
    input  logic             i_pop,
    output sm4_entry_t       o_rdata,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_drop
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    sm4_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~w_full | w_pop);
    assign o_drop = i_push & w_full & ~w_pop;

    // NOTE: the storage array has no reset; only pointers and count need one,
    // and leaving it out keeps the array mappable to plain RAM/flops without
    // a reset tree. Stale contents are never visible while o_empty is high.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of
    // process order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sm4_stream_sched.sv
// -----------------------------------------------------------------------------
// sm4_stream_sched
// Scheduler in front of a pipelined SM4 enc/dec core. Loads keys into the
// core, keeps the core mode stable while blocks are in flight, issues blocks
// under a credit limit and buffers results so downstream may stall.
// Ports:
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_key/i_key_valid/o_key_ready: key load request
//   s_req_*                      : block request (data + decrypt flag)
//   m_valid/m_ready/m_data/m_dec : result stream (FIFO head)
//   o_core_key/o_core_key_valid  : key and one-cycle load pulse to the core
//   o_core_mode                  : core mode (00 idle, 01 enc, 10 dec)
//   o_core_data/o_core_valid     : block issue to the core
//   i_core_ready/data/valid      : core ready and result
//   o_busy                       : blocks in flight or not settled in RUN
//   o_err                        : sticky key timeout / unexpected result
// -----------------------------------------------------------------------------
module sm4_stream_sched
    import sm4_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = $clog2(FIFO_DEPTH + 1),
    parameter int KEY_TIMEOUT = 1024
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic         s_req_valid,
    output logic         s_req_ready,
    input  logic         s_req_dec,
    input  logic [127:0] s_req_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         m_dec,
    output logic [127:0] o_core_key,
    output logic         o_core_key_valid,
    output logic [1:0]   o_core_mode,
    output logic [127:0] o_core_data,
    output logic         o_core_valid,
    input  logic         i_core_ready,
    input  logic [127:0] i_core_data,
    input  logic         i_core_valid,
    output logic         o_busy,
    output logic         o_err
);

    localparam int               TMR_W      = $clog2(KEY_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(KEY_TIMEOUT - 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    logic [2:0]       r_state;
    logic [127:0]     r_core_key;
    logic             r_core_key_valid;
    logic [127:0]     r_key_buf;
    logic             r_key_pend;
    logic [1:0]       r_core_mode;
    logic             r_mode_dec;
    logic [127:0]     r_core_data;
    logic             r_core_valid;
    logic [CNT_W-1:0] r_inflight;
    logic [TMR_W-1:0] r_timer;
    logic             r_err;

    logic             w_key_acc;
    logic [1:0]       w_req_mode;
    logic             w_credit_ok;
    logic             w_issue;
    logic             w_drained;
    logic             w_kwait_done;
    logic             w_key_timeout;
    logic             w_spurious;
    sm4_entry_t       w_fifo_wdata;
    sm4_entry_t       w_fifo_rdata;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_drop;

    // ---------------------------------------------------------------- handshakes
    assign o_key_ready = (r_state == ST_NOKEY) || (r_state == ST_RUN);
    assign w_key_acc   = i_key_valid & o_key_ready;
    assign w_req_mode  = sm4_mode_of(s_req_dec);

    // Blocks in flight plus results waiting must fit in the FIFO, so a result
    // from the core (which cannot be stalled) always finds a free entry.
    assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < CREDIT_MAX;

    // A key accepted this cycle takes priority over a block request.
    assign s_req_ready = (r_state == ST_RUN) & i_core_ready & (w_req_mode == r_core_mode)
                       & w_credit_ok & ~w_key_acc;
    assign w_issue     = s_req_valid & s_req_ready;

    // The mode may only move once nothing is in the core or in the issue register.
    assign w_drained   = (r_inflight == '0) & ~r_core_valid;

    // i_core_ready may still reflect the previous key right after the pulse,
    // so the first KWAIT cycle (timer == 0) never completes the wait.
    assign w_kwait_done  = (r_timer != '0) & i_core_ready;
    assign w_key_timeout = (r_state == ST_KWAIT) & ~w_kwait_done & (r_timer == TMR_LAST);
    assign w_spurious    = i_core_valid & (r_inflight == '0);

    // ---------------------------------------------------------------- FSM + key
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= ST_NOKEY;
            r_core_key       <= '0;
            r_core_key_valid <= 1'b0;
            r_key_buf        <= '0;
            r_key_pend       <= 1'b0;
            r_core_mode      <= SM4_MODE_IDLE;
            r_mode_dec       <= 1'b0;
            r_timer          <= '0;
        end else begin
            r_core_key_valid <= 1'b0;
            case (r_state)
                ST_NOKEY: begin
                    if (w_key_acc) begin
                        r_core_key       <= i_key;
                        r_core_key_valid <= 1'b1;
                        r_state          <= ST_KPULSE;
                    end
                end
                ST_KPULSE: begin
                    r_timer <= '0;
                    r_state <= ST_KWAIT;
                end
                ST_KWAIT: begin
                    if (w_kwait_done) begin
                        r_core_mode <= sm4_mode_of(r_mode_dec);
                        r_state     <= ST_RUN;
                    end else if (w_key_timeout) begin
                        r_state <= ST_NOKEY;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_key_acc) begin
                        // Hold the new key aside; the core keeps the old one
                        // until every block issued under it has returned.
                        r_key_buf  <= i_key;
                        r_key_pend <= 1'b1;
                        r_state    <= ST_DRAIN;
                    end else if (s_req_valid && (w_req_mode != r_core_mode)) begin
                        r_mode_dec <= s_req_dec;
                        r_state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        if (r_key_pend) begin
                            r_core_key       <= r_key_buf;
                            r_core_key_valid <= 1'b1;
                            r_key_pend       <= 1'b0;
                            r_core_mode      <= SM4_MODE_IDLE;
                            r_state          <= ST_KPULSE;
                        end else begin
                            r_core_mode <= sm4_mode_of(r_mode_dec);
                            r_state     <= ST_RUN;
                        end
                    end
                end
                default: r_state <= ST_NOKEY;
            endcase
        end
    end

    // ---------------------------------------------------------------- issue path
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_core_valid <= 1'b0;
            r_core_data  <= '0;
        end else begin
            r_core_valid <= w_issue;
            if (w_issue) begin
                r_core_data <= s_req_data;
            end
        end
    end

    // Blocks between acceptance and their result leaving the core.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, i_core_valid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= (r_inflight != '0) ? r_inflight - 1'b1 : r_inflight;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_key_timeout || w_spurious || w_fifo_drop) begin
            r_err <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- results
    // The mode is frozen while blocks are in flight, so the live mode is the
    // mode each returning block was processed with.
    assign w_fifo_wdata.dec  = (r_core_mode == SM4_MODE_DEC);
    assign w_fifo_wdata.data = i_core_data;

    sm4_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_core_valid),
        .i_wdata (w_fifo_wdata),
        .i_pop   (m_valid & m_ready),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_drop  (w_fifo_drop)
    );

    assign m_valid = ~w_fifo_empty;
    // Gated so the result bus reads zero rather than stale storage when empty.
    assign m_data  = m_valid ? w_fifo_rdata.data : '0;
    assign m_dec   = m_valid & w_fifo_rdata.dec;

    // ---------------------------------------------------------------- outputs
    assign o_core_key       = r_core_key;
    assign o_core_key_valid = r_core_key_valid;
    assign o_core_mode      = r_core_mode;
    assign o_core_data      = r_core_data;
    assign o_core_valid     = r_core_valid;
    assign o_err            = r_err;
    // NOKEY is idle (nothing to finish), so it does not count as busy.
    assign o_busy = (r_inflight != '0) || ((r_state != ST_RUN) && (r_state != ST_NOKEY));

endmodule
